// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// State encoding, default sizing and the binary-to-Gray mapping.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 1;
    localparam int MAX_N_IN   = 16;

    function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/tt_vec_gen.sv
// Step counter and stimulus vector mapping (binary, or Gray when TT_SWEEP_GRAY_EN is defined).
// Latency: vec is a registered step value, combinationally mapped; advances one edge after adv.
// Backpressure: none; the step only moves when the controller pulses adv.
module tt_vec_gen
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            adv,
    output logic [N_IN-1:0] vec,
    output logic            last
);

    logic [N_IN-1:0] step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else if (clr) begin
            step_q <= '0;
        end else if (adv) begin
            step_q <= step_q + 1'b1;
        end
    end

    assign last = &step_q;

`ifdef TT_SWEEP_GRAY_EN
    logic [MAX_N_IN-1:0] gray;
    assign gray = bin2gray(MAX_N_IN'(step_q));
    assign vec  = gray[N_IN-1:0];
`else
    assign vec = step_q;
`endif

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2**N_IN vectors into a boolean block, captures its truth table and checks it against a mask.
// Latency: SETTLE+1 cycles per vector; done pulses 2**N_IN*(SETTLE+1) edges after the accept edge.
// Backpressure: start is ignored while busy; vector order is binary, or Gray under TT_SWEEP_GRAY_EN.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        vec,
    output logic                   vec_valid,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   match,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err_idx,
    output logic                   first_err_valid
);

    localparam int SCW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = (SETTLE > 0) ? SCW'(SETTLE - 1) : '0;

    state_t state_q, state_d;
    logic [SCW-1:0]        settle_q;
    logic                  settle_done;
    logic                  accept, sample, adv, last;
    logic [(1<<N_IN)-1:0]  expected_q, table_q;
    logic [N_IN:0]         err_q;
    logic [N_IN-1:0]       first_idx_q;
    logic                  first_vld_q, match_q, busy_q;

    assign settle_done = (settle_q == SETTLE_LAST);
    assign accept      = (state_q == ST_IDLE) && start;
    assign sample      = (state_q == ST_SAMPLE);
    assign adv         = sample && !last;

    tt_vec_gen #(.N_IN(N_IN)) u_vec_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .adv   (adv),
        .vec   (vec),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
            end
            ST_WAIT: begin
                vec_valid = 1'b1;
                if (settle_done) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                vec_valid = 1'b1;
                if (last) state_d = ST_DONE;
                else      state_d = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
        end else if (state_q == ST_WAIT) begin
            settle_q <= settle_done ? '0 : settle_q + 1'b1;
        end else begin
            settle_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_q  <= '0;
            table_q     <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            expected_q  <= expected;
            table_q     <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            match_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else if (sample) begin
            table_q[vec] <= f_in;
            if (f_in != expected_q[vec]) begin
                err_q <= err_q + (N_IN+1)'(1);
                // Sweep order, not index order, decides which mismatch is "first".
                if (!first_vld_q) begin
                    first_idx_q <= vec;
                    first_vld_q <= 1'b1;
                end
            end
        end else if (state_q == ST_DONE) begin
            match_q <= (err_q == '0);
            busy_q  <= 1'b0;
        end
    end

    assign busy            = busy_q;
    assign table_out       = table_q;
    assign match           = match_q;
    assign err_count       = err_q;
    assign first_err_idx   = first_idx_q;
    assign first_err_valid = first_vld_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: PoS model function, clean/faulty masks, re-start and mid-sweep reset.
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected = '0;
    logic [3:0]  vec;
    logic        vec_valid;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        match;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        first_err_valid;
    logic        f_zero = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tt_sweep_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .expected        (expected),
        .vec             (vec),
        .vec_valid       (vec_valid),
        .f_in            (f_in),
        .busy            (busy),
        .done            (done),
        .table_out       (table_out),
        .match           (match),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    // f is zero exactly on the maxterms {0,1,6,7,8,9,12,14}.
    function automatic logic model_f(input logic [3:0] v);
        return !(v inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd14});
    endfunction

    function automatic logic [3:0] sweep_vec(input int k);
        logic [3:0] s;
        s = 4'(k);
`ifdef TT_SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    assign f_in = f_zero ? 1'b0 : model_f(vec);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " vec"}, 32'(vec), 0);
        check({tag, " vec_valid"}, 32'(vec_valid), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " table"}, 32'(table_out), 0);
        check({tag, " match"}, 32'(match), 0);
        check({tag, " err_count"}, 32'(err_count), 0);
        check({tag, " first_idx"}, 32'(first_err_idx), 0);
        check({tag, " first_vld"}, 32'(first_err_valid), 0);
    endtask

    // Start in cycle 0 (sampled at the next edge); cycle c is observed at the c-th negedge after.
    task automatic run_sweep(input string tag, input logic [15:0] exp_v, input bit zero_f,
                             input bit repulse, input bit scramble);
        logic [15:0] tab;
        int          n_err, first_k, ndone, done_cyc;
        logic [3:0]  v;
        tab = '0;
        n_err = 0;
        first_k = -1;
        for (int k = 0; k < 16; k++) begin
            v = sweep_vec(k);
            tab[v] = zero_f ? 1'b0 : model_f(v);
            if (tab[v] != exp_v[v]) begin
                n_err++;
                if (first_k < 0) first_k = k;
            end
        end
        @(negedge clk);
        f_zero   = zero_f;
        expected = exp_v;
        start    = 1'b1;
        ndone    = 0;
        done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 32) begin
                check($sformatf("%s vec_valid c%0d", tag, c), 32'(vec_valid), 1);
                check($sformatf("%s vec c%0d", tag, c), 32'(vec), 32'(sweep_vec((c - 1) / 2)));
            end
            if (c == 1) check({tag, " busy"}, 32'(busy), 1);
            if (done) begin
                ndone++;
                done_cyc = c;
                check({tag, " busy at done"}, 32'(busy), 1);
            end
            start = repulse && (c == 10 || c == 33);
            if (scramble) expected = 16'($urandom);
        end
        start = 1'b0;
        check({tag, " done count"}, 32'(ndone), 1);
        check({tag, " done cycle"}, 32'(done_cyc), 33);
        check({tag, " busy after"}, 32'(busy), 0);
        check({tag, " vec_valid after"}, 32'(vec_valid), 0);
        check({tag, " table"}, 32'(table_out), 32'(tab));
        check({tag, " match"}, 32'(match), 32'(n_err == 0));
        check({tag, " err_count"}, 32'(err_count), 32'(n_err));
        check({tag, " first_vld"}, 32'(first_err_valid), 32'(first_k >= 0));
        check({tag, " first_idx"}, 32'(first_err_idx),
              (first_k >= 0) ? 32'(sweep_vec(first_k)) : 32'd0);
    endtask

    initial begin
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("idle");

        run_sweep("clean", 16'hAC3C, 1'b0, 1'b0, 1'b0);
        check("clean table const", 32'(table_out), 32'h0000AC3C);
        check("clean match const", 32'(match), 1);

        run_sweep("onebit", 16'hAC3D, 1'b0, 1'b0, 1'b0);
        run_sweep("allwrong", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check("allwrong err const", 32'(err_count), 32'h10);
        run_sweep("gray_mask", 16'hAC3E, 1'b0, 1'b0, 1'b0);
        run_sweep("repulse", 16'hAC3C, 1'b0, 1'b1, 1'b0);
        run_sweep("scramble", 16'h5A3C, 1'b0, 1'b0, 1'b1);

        // Mid-sweep reset: outputs clear asynchronously, no done afterwards.
        @(negedge clk);
        f_zero   = 1'b0;
        expected = 16'hAC3C;
        start    = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("post-reset quiet c%0d", c), 32'({done, busy, vec_valid}), 0);
        end
        run_sweep("after_reset", 16'hAC3C, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
